// File: rtl/traffic_light_monitor_if.sv
// Lamp bundle plus monitor status, shared by a lamp driver and the monitor.
// Latency: none (wires only).
// Backpressure: none; lamps are sampled every clock, status is always valid.
interface traffic_light_monitor_if;
  logic       red;
  logic       yellow;
  logic       green;
  logic [2:0] phase;
  logic       locked;
  logic       cycle_done;
  logic       err_pulse;
  logic [2:0] err_code;
  logic [7:0] err_count;

  // Lamp driver side: drives the lamps, observes monitor status.
  modport master (
    output red, yellow, green,
    input  phase, locked, cycle_done, err_pulse, err_code, err_count
  );

  // Monitor side: samples the lamps, reports status.
  modport slave (
    input  red, yellow, green,
    output phase, locked, cycle_done, err_pulse, err_code, err_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for a red/yellow/green lamp set: phase order, phase durations, illegal lamps.
// Latency: 1 clk from lamp change to every status output (all outputs registered).
// Backpressure: none; lamps are sampled unconditionally on every rising edge.
module traffic_light_monitor #(
  parameter int RED_T    = 6,
  parameter int REDYLW_T = 2,
  parameter int GREEN_T  = 6,
  parameter int YELLOW_T = 2,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  traffic_light_monitor_if.slave  mon
);

  typedef enum logic [2:0] {
    PH_NONE    = 3'd0,
    PH_RED     = 3'd1,
    PH_RED_YLW = 3'd2,
    PH_GREEN   = 3'd3,
    PH_YELLOW  = 3'd4,
    PH_ILLEGAL = 3'd7
  } phase_t;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_ILLEGAL   = 3'd1,
    ERR_BAD_ORDER = 3'd2,
    ERR_SHORT     = 3'd3,
    ERR_LONG      = 3'd4
  } err_t;

  // Legal successor of each phase; NONE/ILLEGAL have no successor.
  function automatic phase_t succ_of(input phase_t p);
    case (p)
      PH_RED:     succ_of = PH_RED_YLW;
      PH_RED_YLW: succ_of = PH_GREEN;
      PH_GREEN:   succ_of = PH_YELLOW;
      PH_YELLOW:  succ_of = PH_RED;
      default:    succ_of = PH_NONE;
    endcase
  endfunction

  // Expected duration of each phase, one bit wider than the counter for compares.
  function automatic logic [CNT_W:0] t_of(input phase_t p);
    case (p)
      PH_RED:     t_of = (CNT_W+1)'(RED_T);
      PH_RED_YLW: t_of = (CNT_W+1)'(REDYLW_T);
      PH_GREEN:   t_of = (CNT_W+1)'(GREEN_T);
      PH_YELLOW:  t_of = (CNT_W+1)'(YELLOW_T);
      default:    t_of = '0;
    endcase
  endfunction

  phase_t           phase_q, phase_d, cur, succ_prev;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W:0]   dur_inc, t_prev;
  logic             locked_q, locked_d;
  logic             cycle_done_q, cycle_done_d;
  logic             err_pulse_q, err_pulse_d;
  err_t             err_code_q, err_code_d, err_kind;
  logic             err_hit;
  logic [7:0]       err_count_q, err_count_d;

  // Decode the current lamp sample into a phase.
  always_comb begin
    case ({mon.red, mon.yellow, mon.green})
      3'b100:  cur = PH_RED;
      3'b110:  cur = PH_RED_YLW;
      3'b001:  cur = PH_GREEN;
      3'b010:  cur = PH_YELLOW;
      default: cur = PH_ILLEGAL;
    endcase
  end

  assign succ_prev = succ_of(phase_q);
  assign t_prev    = t_of(phase_q);
  // Unsaturated next count; the extra bit flags counter overflow.
  assign dur_inc   = {1'b0, dur_q} + (CNT_W+1)'(1);

  // Next-state: duration tracking, transition checks, lock and error bookkeeping.
  always_comb begin
    phase_d      = cur;
    dur_d        = dur_q;
    locked_d     = locked_q;
    cycle_done_d = 1'b0;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    err_count_d  = err_count_q;
    err_hit      = 1'b0;
    err_kind     = ERR_NONE;

    if (cur == phase_q) begin
      dur_d = dur_inc[CNT_W] ? dur_q : dur_inc[CNT_W-1:0];
      // Fires exactly once: the edge where the phase outstays its slot by one sample.
      if (locked_q && (dur_inc == t_prev + (CNT_W+1)'(1))) begin
        err_hit  = 1'b1;
        err_kind = ERR_LONG;
      end
    end else begin
      dur_d = CNT_W'(1);
      if (cur == PH_ILLEGAL) begin
        err_hit  = 1'b1;
        err_kind = ERR_ILLEGAL;
      end else if (locked_q && (cur != succ_prev)) begin
        err_hit  = 1'b1;
        err_kind = ERR_BAD_ORDER;
      end else if (locked_q && ({1'b0, dur_q} < t_prev)) begin
        err_hit  = 1'b1;
        err_kind = ERR_SHORT;
      end else if (locked_q) begin
        cycle_done_d = (phase_q == PH_YELLOW);
      end else if ((phase_q != PH_NONE) && (phase_q != PH_ILLEGAL) && (cur == succ_prev)) begin
        // The phase we just left may have been partial, so it is not timed.
        locked_d = 1'b1;
      end
    end

    if (err_hit) begin
      err_pulse_d = 1'b1;
      err_code_d  = err_kind;
      err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
      locked_d    = 1'b0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q      <= PH_NONE;
      dur_q        <= '0;
      locked_q     <= 1'b0;
      cycle_done_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_count_q  <= 8'd0;
    end else begin
      phase_q      <= phase_d;
      dur_q        <= dur_d;
      locked_q     <= locked_d;
      cycle_done_q <= cycle_done_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      err_count_q  <= err_count_d;
    end
  end

  assign mon.phase      = phase_q;
  assign mon.locked     = locked_q;
  assign mon.cycle_done = cycle_done_q;
  assign mon.err_pulse  = err_pulse_q;
  assign mon.err_code   = err_code_q;
  assign mon.err_count  = err_count_q;

endmodule
